// File: rtl/dpe_input_arbiter.sv
// Packet-level round-robin arbiter sharing the DPE ingress stream between CPU and ETH_1..ETH_4.
// Optional per-port packet counters are built when DPE_ARB_STATS_EN is defined.
module dpe_input_arbiter #(
  parameter int N_PORTS = 5,
  parameter int DATA_W  = 128,
  parameter int KEEP_W  = DATA_W / 8,
  parameter int ADDR_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          s_tvalid,
  output logic [N_PORTS-1:0]          s_tready,
  input  logic [N_PORTS*DATA_W-1:0]   s_tdata,
  input  logic [N_PORTS*KEEP_W-1:0]   s_tkeep,
  input  logic [N_PORTS-1:0]          s_tlast,
  input  logic [N_PORTS-1:0]          s_tuser_bypass_all,
  input  logic [N_PORTS-1:0]          s_tuser_bypass_stage,
  input  logic [N_PORTS*ADDR_W-1:0]   s_tuser_dst,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [KEEP_W-1:0]           m_tkeep,
  output logic                        m_tlast,
  output logic                        m_tuser_bypass_all,
  output logic                        m_tuser_bypass_stage,
  output logic [ADDR_W-1:0]           m_tuser_src,
  output logic [ADDR_W-1:0]           m_tuser_dst,
  output logic                        busy
`ifdef DPE_ARB_STATS_EN
  ,
  input  logic                        stat_clr,
  output logic [N_PORTS*16-1:0]       stat_pkt_cnt
`endif
);

  // state | meaning
  // IDLE  | no grant held; one arbitration cycle scanning from rr_ptr
  // BUSY  | grant held on r_grant until its tlast beat is accepted

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W:0]   w_scan_idx;
  logic             w_req_found;
  logic             w_out_free;
  logic             w_accept;
  logic             w_accept_last;

  logic              r_m_tvalid;
  logic [DATA_W-1:0] r_m_tdata;
  logic [KEEP_W-1:0] r_m_tkeep;
  logic              r_m_tlast;
  logic              r_m_bypass_all;
  logic              r_m_bypass_stage;
  logic [ADDR_W-1:0] r_m_src;
  logic [ADDR_W-1:0] r_m_dst;

  // First requester at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    w_sel       = r_rr_ptr;
    w_req_found = 1'b0;
    w_scan_idx  = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      w_scan_idx = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_scan_idx >= (IDX_W+1)'(N_PORTS))
        w_scan_idx = w_scan_idx - (IDX_W+1)'(N_PORTS);
      if (!w_req_found && s_tvalid[w_scan_idx]) begin
        w_req_found = 1'b1;
        w_sel       = w_scan_idx[IDX_W-1:0];
      end
    end
  end

  assign w_out_free    = !r_m_tvalid || m_tready;
  assign w_accept      = (r_state == ST_BUSY) && s_tvalid[r_grant] && w_out_free;
  assign w_accept_last = w_accept && s_tlast[r_grant];
  assign busy          = (r_state == ST_BUSY);

  always_comb begin
    s_tready = '0;
    if (r_state == ST_BUSY && w_out_free)
      s_tready[r_grant] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_req_found) begin
          w_state_nxt = ST_BUSY;
          w_grant_nxt = w_sel;
        end
      end
      ST_BUSY: begin
        if (w_accept_last) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = (r_grant == IDX_W'(N_PORTS-1)) ? '0 : r_grant + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  // Source address equals the port index; any upstream src value is ignored.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_tvalid       <= 1'b0;
      r_m_tdata        <= '0;
      r_m_tkeep        <= '0;
      r_m_tlast        <= 1'b0;
      r_m_bypass_all   <= 1'b0;
      r_m_bypass_stage <= 1'b0;
      r_m_src          <= '0;
      r_m_dst          <= '0;
    end else if (w_accept) begin
      r_m_tvalid       <= 1'b1;
      r_m_tdata        <= s_tdata[int'(r_grant)*DATA_W +: DATA_W];
      r_m_tkeep        <= s_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];
      r_m_tlast        <= s_tlast[r_grant];
      r_m_bypass_all   <= s_tuser_bypass_all[r_grant];
      r_m_bypass_stage <= s_tuser_bypass_stage[r_grant];
      r_m_src          <= ADDR_W'(r_grant);
      r_m_dst          <= s_tuser_dst[int'(r_grant)*ADDR_W +: ADDR_W];
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid             = r_m_tvalid;
  assign m_tdata              = r_m_tdata;
  assign m_tkeep              = r_m_tkeep;
  assign m_tlast              = r_m_tlast;
  assign m_tuser_bypass_all   = r_m_bypass_all;
  assign m_tuser_bypass_stage = r_m_bypass_stage;
  assign m_tuser_src          = r_m_src;
  assign m_tuser_dst          = r_m_dst;

`ifdef DPE_ARB_STATS_EN
  logic [15:0] r_pkt_cnt [N_PORTS];

  // Clear takes priority over a same-cycle increment; counts saturate.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_PORTS; i++) begin
      if (!rst || stat_clr)
        r_pkt_cnt[i] <= '0;
      else if (w_accept_last && r_grant == IDX_W'(i) && r_pkt_cnt[i] != 16'hFFFF)
        r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int i = 0; i < N_PORTS; i++)
      stat_pkt_cnt[i*16 +: 16] = r_pkt_cnt[i];
  end
`endif

endmodule

// File: tb/tb_dpe_input_arbiter.sv
// Self-checking bench for dpe_input_arbiter: directed phases plus randomized traffic
// checked against a packet-level round-robin model. Define DPE_ARB_STATS_EN to cover counters.
module tb_dpe_input_arbiter;
  localparam int N  = 5;
  localparam int DW = 128;
  localparam int KW = DW / 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    s_tvalid, s_tready, s_tlast, s_ba, s_bs;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N*AW-1:0] s_tdst;
  logic            m_tvalid, m_tready, m_tlast, m_ba, m_bs, busy;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic [AW-1:0]   m_src, m_dst;
`ifdef DPE_ARB_STATS_EN
  logic            stat_clr = 1'b0;
  logic [N*16-1:0] stat_pkt_cnt;
  bit              clr_arm = 1'b0;
`endif

  dpe_input_arbiter dut (
    .clk(clk), .rst(rst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep),
    .s_tlast(s_tlast), .s_tuser_bypass_all(s_ba), .s_tuser_bypass_stage(s_bs),
    .s_tuser_dst(s_tdst),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser_bypass_all(m_ba), .m_tuser_bypass_stage(m_bs),
    .m_tuser_src(m_src), .m_tuser_dst(m_dst), .busy(busy)
`ifdef DPE_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_pkt_cnt(stat_pkt_cnt)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last, ba, bs;
    logic [AW-1:0] dst, src;
  } beat_t;

  beat_t src_q [N][$];
  int    plen  [N][$];
  beat_t exp_q [$];
  bit    mid   [N];
  int    tb_rr = 0;
  int    pat_i = 0;
  int    n_cmp = 0, n_fail = 0;
  int    cyc = 0;
  bit    mon_en = 0, log_en = 0, prev_stall = 0;
  int    log_cyc [$];
  bit    log_last [$];
  logic [DW-1:0]  prev_data;
  logic [159:0]   prev_hdr;
  bit    tr_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] hdr_now();
    return {m_tkeep, m_tlast, m_ba, m_bs, m_src, m_dst, m_tvalid};
  endfunction

  // Output monitor: every handshaked beat must be the next one the model predicts.
  always @(negedge clk) begin
    if (mon_en) begin
      check("tready_onehot0", {159'd0, $onehot0(s_tready)}, 160'd1);
      if (s_tready != '0) check("tready_needs_busy", {159'd0, busy}, 160'd1);
      if (prev_stall) begin
        check("stall_data", m_tdata, prev_data);
        check("stall_hdr", hdr_now(), prev_hdr);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", exp_q.size(), 1);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", m_tdata, e.data);
          check("beat_hdr", {m_tkeep, m_tlast, m_ba, m_bs, m_src, m_dst},
                {e.keep, e.last, e.ba, e.bs, e.src, e.dst});
        end
        if (log_en) begin
          log_cyc.push_back(cyc);
          log_last.push_back(m_tlast);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_hdr   = hdr_now();
    end
  end

  task automatic add_pkt(input int port, input int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.data = {$urandom, $urandom, $urandom, $urandom};
      x.keep = KW'($urandom);
      x.last = (b == len - 1);
      x.ba   = 1'($urandom);
      x.bs   = 1'($urandom);
      x.dst  = AW'($urandom);
      x.src  = AW'(port);
      src_q[port].push_back(x);
    end
    plen[port].push_back(len);
  endtask

  // Packet-level model: whole packets, granted round-robin among ports with work left.
  task automatic build_expected();
    int rem [N];
    int off [N];
    int pi  [N];
    int total, p, port;
    total = 0;
    for (int i = 0; i < N; i++) begin
      rem[i] = plen[i].size(); off[i] = 0; pi[i] = 0; total += rem[i];
    end
    p = tb_rr;
    while (total > 0) begin
      port = -1;
      for (int k = 0; k < N; k++)
        if (port < 0 && rem[(p + k) % N] > 0) port = (p + k) % N;
      for (int b = 0; b < plen[port][pi[port]]; b++)
        exp_q.push_back(src_q[port][off[port] + b]);
      off[port] += plen[port][pi[port]];
      pi[port]++;
      rem[port]--;
      total--;
      p = (port + 1) % N;
    end
    tb_rr = p;
    for (int i = 0; i < N; i++) plen[i].delete();
  endtask

  task automatic drive(input bit bubble_en);
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        beat_t b;
        b = src_q[i][0];
        s_tvalid[i] = !(mid[i] && bubble_en && $urandom_range(0, 2) == 0);
        s_tdata[i*DW +: DW] = b.data;
        s_tkeep[i*KW +: KW] = b.keep;
        s_tlast[i] = b.last;
        s_ba[i] = b.ba;
        s_bs[i] = b.bs;
        s_tdst[i*AW +: AW] = b.dst;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tlast[i]  = 1'b0;
      end
    end
  endtask

  task automatic set_tready(input int mode);
    if (mode == 0) m_tready = 1'b1;
    else if (mode == 1) begin m_tready = tr_pat[pat_i % 7]; pat_i++; end
    else m_tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic step(input bit bubble_en, input int mode);
    logic [N-1:0] acc;
    @(negedge clk);
    acc = s_tvalid & s_tready;
`ifdef DPE_ARB_STATS_EN
    if (clr_arm && acc[1] && s_tlast[1]) begin stat_clr = 1'b1; clr_arm = 1'b0; end
`endif
    @(posedge clk); #1;
`ifdef DPE_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        beat_t b;
        b = src_q[i].pop_front();
        mid[i] = !b.last;
      end
    end
    drive(bubble_en);
    set_tready(mode);
  endtask

  function automatic int pending();
    int s;
    s = exp_q.size();
    for (int i = 0; i < N; i++) s += src_q[i].size();
    return s;
  endfunction

  task automatic run_phase(input string tag, input bit bubble_en, input int mode, input int budget);
    int n;
    build_expected();
    drive(bubble_en);
    set_tready(mode);
    n = 0;
    while (pending() > 0 && n < budget) begin
      step(bubble_en, mode);
      n++;
    end
    check(tag, pending(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    s_ba = '0; s_bs = '0; s_tdst = '0; m_tready = 1'b1;
    for (int i = 0; i < N; i++) mid[i] = 1'b0;

    // Reset with every port requesting.
    rst = 1'b0;
    s_tvalid = '1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_m_tvalid", {159'd0, m_tvalid}, 160'd0);
      check("rst_s_tready", {155'd0, s_tready}, 160'd0);
      check("rst_busy", {159'd0, busy}, 160'd0);
    end
    check("rst_out_regs", {m_tdata, m_tkeep, m_tlast, m_ba, m_bs, m_src, m_dst}, 160'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    s_tvalid = '0;
    mon_en = 1'b1;

    // Contention: one 4-beat packet per port, order 0..4 with one idle cycle between packets.
    for (int i = 0; i < N; i++) add_pkt(i, 4);
    log_en = 1'b1;
    run_phase("contention_drain", 1'b0, 0, 200);
    log_en = 1'b0;
    check("contention_beats", log_cyc.size(), 20);
    for (int j = 1; j < log_cyc.size(); j++)
      check("contention_gap", log_cyc[j] - log_cyc[j-1], log_last[j-1] ? 2 : 1);

    // Back-pressure on port 2 while port 3 keeps requesting.
    add_pkt(2, 6);
    add_pkt(3, 4);
    pat_i = 0;
    run_phase("backpressure_drain", 1'b0, 1, 300);

    // Port 4 finishes, then ports 0 and 4 compete: pointer has wrapped to 0.
    add_pkt(4, 3);
    run_phase("wrap_p4_drain", 1'b0, 0, 100);
    add_pkt(0, 2);
    add_pkt(4, 2);
    run_phase("wrap_fair_drain", 1'b0, 0, 100);

    // Randomized traffic: bubbles, single-beat packets, random back-pressure.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int k = 0; k < np; k++) add_pkt(i, $urandom_range(1, 6));
      end
      run_phase("random_drain", 1'b1, 2, 2000);
    end

`ifdef DPE_ARB_STATS_EN
    m_tready = 1'b1;
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    for (int k = 0; k < 3; k++) add_pkt(1, $urandom_range(1, 4));
    run_phase("stats_drain", 1'b0, 0, 200);
    @(negedge clk);
    check("stats_cnt3", stat_pkt_cnt[31:16], 3);
    clr_arm = 1'b1;
    add_pkt(1, 1);
    run_phase("stats_clr_drain", 1'b0, 0, 100);
    @(negedge clk);
    check("stats_clr_wins", stat_pkt_cnt[31:16], 0);
    @(posedge clk); #1;
`endif

    // Reset while beat 3 of a 5-beat port 1 packet is presented; beats 1-2 already emitted.
    m_tready = 1'b1;
    add_pkt(1, 5);
    plen[1].delete();
    exp_q.push_back(src_q[1][0]);
    exp_q.push_back(src_q[1][1]);
    drive(1'b0);
    for (int n = 0; n < 50 && src_q[1].size() > 3; n++) step(1'b0, 0);
    check("midrst_two_accepted", src_q[1].size(), 3);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_tvalid", {159'd0, m_tvalid}, 160'd0);
    check("midrst_busy", {159'd0, busy}, 160'd0);
    check("midrst_s_tready", {155'd0, s_tready}, 160'd0);
    check("midrst_partial_out", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); plen[i].delete(); mid[i] = 1'b0; end
    drive(1'b0);
    tb_rr = 0;
    add_pkt(0, 2);
    add_pkt(3, 3);
    run_phase("post_rst_drain", 1'b0, 0, 100);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dpe_input_arbiter.md
Name: dpe_input_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single DPE ingress stream between five sources: CPU and ETH_1..ETH_4.
- Sits in front of the DPE pipeline, mirroring dpe_demultiplexer at the egress.
- Grants one source per packet, holds the grant until that source's tlast beat is accepted, and stamps tuser_src with the granted source's address.
- The output is one registered stage.

Parameters:
- N_PORTS, 5: number of sources. Index 0 = DPE_ADDR_CPU; 1..4 = DPE_ADDR_ETH_1..DPE_ADDR_ETH_4.
- DATA_W, 128: tdata width.
- KEEP_W, DATA_W/8: tkeep width.
- ADDR_W, 3: width of tuser_src/tuser_dst, matching dpe_pkg address type.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- s_tvalid  in  N_PORTS  per-source valid
- s_tready  out  N_PORTS  per-source ready
- s_tdata  in  N_PORTS*DATA_W  per-source data, port i at [i*DATA_W +: DATA_W]
- s_tkeep  in  N_PORTS*KEEP_W  per-source byte keep
- s_tlast  in  N_PORTS  per-source end of packet
- s_tuser_bypass_all  in  N_PORTS  per-source bypass-all flag
- s_tuser_bypass_stage  in  N_PORTS  per-source bypass-stage flag
- s_tuser_dst  in  N_PORTS*ADDR_W  per-source destination
- m_tvalid  out  1  arbitrated output valid
- m_tready  in  1  downstream ready
- m_tdata  out  DATA_W  output data
- m_tkeep  out  KEEP_W  output keep
- m_tlast  out  1  output end of packet
- m_tuser_bypass_all  out  1  forwarded flag
- m_tuser_bypass_stage  out  1  forwarded flag
- m_tuser_src  out  ADDR_W  address of the granted source
- m_tuser_dst  out  ADDR_W  forwarded destination
- busy  out  1  high while a packet grant is held

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=0, grant=none.
  - m_tvalid=0, m_tlast=0, m_tdata/m_tkeep/m_tuser_*=0.
  - s_tready=0, busy=0.
  - Reset mid-packet abandons the packet silently; the partial packet already emitted is not terminated.
- FSM states: IDLE, BUSY.
  - IDLE: s_tready=0. If any s_tvalid, select the first requesting index scanning rr_ptr, rr_ptr+1, ... mod N_PORTS. Register grant_idx; next state BUSY.
  - IDLE with no requests: stay.
  - BUSY: only s_tready[grant_idx] may be high; all other s_tready=0. busy=1.
- Handshake and output register:
  - s_tready[g] = (!m_tvalid || m_tready) in BUSY.
  - On s_tvalid[g] && s_tready[g], load the m_* register from port g next cycle; m_tvalid=1; m_tuser_src = address of port g, overriding any source-supplied value.
  - If m_tready && m_tvalid and no new beat loads, clear m_tvalid next cycle.
  - m_* is stable while m_tvalid && !m_tready.
  - Latency is 1 cycle from input accept to m_tvalid. Full throughput within a packet when m_tready is held high.
- Packet end:
  - An accepted beat with s_tlast[g]=1 → state IDLE, rr_ptr=(g+1) mod N_PORTS.
  - Packets are contiguous at the output: other ports are never interleaved mid-packet.
  - One arbitration cycle is spent in IDLE between packets.
- Boundary conditions:
  - Single-beat packet (tlast on first beat): BUSY lasts for that one handshake only.
  - Granted source drops tvalid mid-packet: the grant is held and bubbles pass through; no timeout.
  - Only one requester: it is re-granted after each packet, with a 1-cycle gap.
  - rr_ptr wraps from N_PORTS-1 to 0.
  - Requests appearing during BUSY wait for the next IDLE cycle.

Optional Feature:
- Macro: DPE_ARB_STATS_EN.
- With the macro defined:
  - Adds input stat_clr (1) and output stat_pkt_cnt (N_PORTS*16).
  - Per-port 16-bit counter increments on each accepted s_tlast beat of that port and saturates at 16'hFFFF.
  - stat_clr=1 zeroes all counters next cycle; clear wins over a simultaneous increment.
  - Counters are zeroed by rst.
- Without the macro: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset check: hold rst=0 for 4 cycles while s_tvalid=5'h1F → m_tvalid=0, s_tready=0, busy=0 throughout.
- Contention: all 5 ports each present one 4-beat packet simultaneously, m_tready=1 → output order is ports 0,1,2,3,4; each packet is 4 contiguous beats; m_tuser_src = CPU, ETH_1..ETH_4; IDLE gap of 1 cycle between packets.
- Back-pressure: port 2 sends a 6-beat packet with m_tready toggling 1,0,1,1,0,0,1… → all 6 beats emerge in order with no loss or duplication; m_* held stable while stalled; port 3 requesting throughout is not granted until port 2's tlast is accepted.
- Fairness and wrap: port 4 finishes a packet, then ports 0 and 4 both request → port 0 granted first (rr_ptr=0 after wrap).
- Reset mid-packet: rst=0 on beat 3 of a 5-beat port 1 packet → next cycle m_tvalid=0, state IDLE, rr_ptr=0; afterwards a port 3 packet is granted normally.
- With DPE_ARB_STATS_EN: 3 packets from port 1 → stat_pkt_cnt[31:16]=3. Pulse stat_clr in the same cycle as a 4th tlast accept → counter reads 0.
